cnn_frame_sequencer: RTL

//  Frame-timing controller for the CNN inference pipeline. Walks a ROWS x COLS position grid and issues
//  one-cycle capture strobes to each layer stage, plus the FCL2->SoftMax load strobe, at fixed grid points.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/cnn_frame_sequencer_if.sv | 33 +++
 rtl/cnn_pos_counter.sv | 40 ++++
 rtl/cnn_frame_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN frame sequencer: FSM state encoding,
// per-stage capture rows and the widths of the position/frame outputs.
// No ports; imported by the interface, the position counter and the top.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  localparam int ROW_W      = 5;
  localparam int COL_W      = 5;
  localparam int FCNT_W     = 8;
  localparam int NSTAGE_MAX = 7;

  // Row at which each layer stage captures; the strobe fires at column 0.
  localparam int STAGE_ROW [NSTAGE_MAX] = '{0, 4, 8, 12, 16, 20, 24};

endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// Control/status bundle between the frame sequencer and its user.
// Ports: start/cont/stall towards the sequencer; busy, done, row, col,
// stage_en, softmax_load and frame_cnt back from it.
interface cnn_frame_sequencer_if
  import cnn_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_MAX
) ();

  logic              start;
  logic              cont;
  logic              stall;
  logic              busy;
  logic              done;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [NSTAGE-1:0] stage_en;
  logic              softmax_load;
  logic [FCNT_W-1:0] frame_cnt;

  // master: the controlling side (pipeline wrapper / testbench)
  modport master (
    output start, cont, stall,
    input  busy, done, row, col, stage_en, softmax_load, frame_cnt
  );

  // slave: the sequencer itself
  modport slave (
    input  start, cont, stall,
    output busy, done, row, col, stage_en, softmax_load, frame_cnt
  );

endinterface

// File: rtl/cnn_pos_counter.sv
// 2-D position counter: col runs 0..COLS-1, then wraps and bumps row
// (row wraps after ROWS-1). Ports: clk, rst, en (advance one position),
// clr (return to 0,0), row/col (registered position), last (at final position).
module cnn_pos_counter
  import cnn_pkg::*;
#(
  parameter int COLS = 26,
  parameter int ROWS = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == COL_W'(COLS - 1));
  assign row_end = (row == ROW_W'(ROWS - 1));
  assign last    = col_end && row_end;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame-timing controller: walks a ROWS x COLS grid and issues one-cycle
// stage capture strobes and the softmax load strobe at fixed grid points.
// Ports: clk, rst (sync, active-high), bus (slave side of cnn_frame_sequencer_if).
module cnn_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int COLS      = 26,
  parameter int ROWS      = 30,
  parameter int NSTAGE    = 7,
  parameter int SM_ROW    = 1,
  parameter int SM_COL    = 9,
  parameter int DRAIN_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cnn_frame_sequencer_if.slave  bus
);

  localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [DCNT_W-1:0] drain_cnt;
  logic [DCNT_W-1:0] drain_cnt_nxt;
  logic [FCNT_W-1:0] frame_cnt_q;

  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic              pos_last;
  logic              pos_en;
  logic              pos_clr;

  logic              adv;
  logic              frame_end;
  logic              drain_last;
  logic              done_c;
  logic [NSTAGE-1:0] stage_hit;

  // A stalled cycle neither moves the position nor strobes, so every grid
  // point strobes exactly once per frame however long the stall lasts.
  assign adv        = (state == ST_RUN) && !bus.stall;
  assign frame_end  = adv && pos_last;
  assign drain_last = (state == ST_DRAIN) && (drain_cnt == DCNT_W'(DRAIN_CYC - 1));

  cnn_pos_counter #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .en   (pos_en),
    .clr  (pos_clr),
    .row  (row_q),
    .col  (col_q),
    .last (pos_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      drain_cnt   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (frame_end) begin
        frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    pos_en        = 1'b0;
    pos_clr       = 1'b0;
    done_c        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_RUN;
          pos_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        if (adv) begin
          if (pos_last) begin
            if (bus.cont) begin
              // Back-to-back frame: the counter wraps itself to (0,0).
              pos_en = 1'b1;
              done_c = 1'b1;
            end else begin
              // Position is left parked on the last point during drain.
              state_nxt     = ST_DRAIN;
              drain_cnt_nxt = '0;
            end
          end else begin
            pos_en = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Drain runs a fixed length regardless of stall.
        if (drain_last) begin
          done_c        = 1'b1;
          state_nxt     = ST_IDLE;
          drain_cnt_nxt = '0;
          pos_clr       = 1'b1;
        end else begin
          drain_cnt_nxt = drain_cnt + DCNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        pos_clr   = 1'b1;
      end
    endcase
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    assign stage_hit[k] = adv && (row_q == ROW_W'(STAGE_ROW[k])) && (col_q == '0);
  end

  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = done_c;
  assign bus.row          = row_q;
  assign bus.col          = col_q;
  assign bus.stage_en     = stage_hit;
  assign bus.softmax_load = adv && (row_q == ROW_W'(SM_ROW)) && (col_q == COL_W'(SM_COL));
  assign bus.frame_cnt    = frame_cnt_q;

endmodule
